// File: rtl/shift_frame_sequencer_pkg.sv
// Shared definitions for the shift frame sequencer: state encoding and the
// default frame geometry used by both the design and its bench.
`timescale 1ns/1ps
package shift_seq_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int GAP_DEF   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_frame_sequencer_counter.sv
// Saturating up-counter with synchronous clear, enable and a terminal-count
// flag. Holds at MAX_VAL instead of wrapping.
`timescale 1ns/1ps
module shift_bit_counter #(
  parameter int CNT_W   = 2,
  parameter int MAX_VAL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority, increment stops at the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == MAX_C);

endmodule

// File: rtl/shift_frame_sequencer.sv
// Serialises a parallel word MSB-first onto a downstream shift register's
// serial input, with a qualifying shift enable, frame start/done pulses and
// an inter-frame hold gap. One frame in flight at a time.
`timescale 1ns/1ps
module shift_frame_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic             serial_out,
  output logic             shift_en,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int BC_W = $clog2(WIDTH);
  localparam int GC_W = $clog2(GAP + 1);

  state_t           state_q;
  logic [WIDTH-1:0] buf_q;
  logic             serial_q;
  logic             shift_en_q;
  logic             fstart_q;
  logic             fdone_q;
  logic             busy_q;
  logic             bit_tc;
  logic             gap_tc;

  // Bit counter: zero on entry to SHIFT, terminal on the last bit
  shift_bit_counter #(
    .CNT_W   (BC_W),
    .MAX_VAL (WIDTH - 1)
  ) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != SHIFT),
    .en_i  (state_q == SHIFT),
    .tc_o  (bit_tc)
  );

  // Gap counter: zero on entry to HOLD, terminal on the last hold cycle
  shift_bit_counter #(
    .CNT_W   (GC_W),
    .MAX_VAL (GAP - 1)
  ) u_gap_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != HOLD),
    .en_i  (state_q == HOLD),
    .tc_o  (gap_tc)
  );

  // Frame FSM with registered outputs; the buffer shifts left so its MSB
  // side always holds the next bit to present
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      serial_q   <= 1'b0;
      shift_en_q <= 1'b0;
      fstart_q   <= 1'b0;
      fdone_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      fstart_q <= 1'b0;
      fdone_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            state_q    <= SHIFT;
            buf_q      <= din;
            serial_q   <= din[WIDTH-1];
            shift_en_q <= 1'b1;
            fstart_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            // abort beats the last-bit transition, so no frame_done
            state_q    <= IDLE;
            serial_q   <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (bit_tc) begin
            state_q    <= HOLD;
            serial_q   <= 1'b0;
            shift_en_q <= 1'b0;
            fdone_q    <= 1'b1;
          end else begin
            serial_q <= buf_q[WIDTH-2];
            buf_q    <= {buf_q[WIDTH-2:0], 1'b0};
          end
        end
        HOLD: begin
          if (gap_tc) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          serial_q   <= 1'b0;
          shift_en_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready   = (state_q == IDLE);
  assign serial_out  = serial_q;
  assign shift_en    = shift_en_q;
  assign frame_start = fstart_q;
  assign frame_done  = fdone_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Directed bench: sequencer driving a serial-in shift register model.
`timescale 1ns/1ps
module tb_shift_frame_sequencer;
  import shift_seq_pkg::*;

  localparam int W = WIDTH_DEF;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         abort;
  logic         serial_out;
  logic         shift_en;
  logic         frame_start;
  logic         frame_done;
  logic         busy;

  logic [W-1:0] q = '0;
  int           cyc = 0;
  int           acc_cnt = 0;
  int           last_acc = 0;
  int           fd_cnt = 0;

  int tests = 0;
  int fails = 0;

  shift_frame_sequencer #(.WIDTH(W), .GAP(GAP_DEF)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .abort       (abort),
    .serial_out  (serial_out),
    .shift_en    (shift_en),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Downstream serial-in shift register
  always @(posedge clk) begin
    if (shift_en) q <= {q[W-2:0], serial_out};
  end

  // Edge bookkeeping: cycle count, accepted words, frame_done pulses
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && din_valid && din_ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= cyc;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] word;
  int a1, acc0, fd0;

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; abort = 1'b0;
    step(); step();
    chk("rst_ready", din_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_shen", shift_en, 0);
    chk("rst_ser", serial_out, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b0;
    step();

    // Single frame 1011
    word = 4'b1011;
    din = word; din_valid = 1'b1;
    step();
    din_valid = 1'b0; din = 4'b0000;
    chk("f1_fstart", frame_start, 1);
    chk("f1_busy", busy, 1);
    chk("f1_ready", din_ready, 0);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("f1_ser%0d", i), serial_out, word[W-1-i]);
      chk($sformatf("f1_shen%0d", i), shift_en, 1);
      if (i > 0) chk($sformatf("f1_fs%0d", i), frame_start, 0);
      chk($sformatf("f1_fd%0d", i), frame_done, 0);
      step();
    end
    chk("f1_done", frame_done, 1);
    chk("f1_q", q, 4'b1011);
    chk("f1_hold_shen", shift_en, 0);
    chk("f1_hold_busy", busy, 1);
    step();
    chk("f1_done_pulse", frame_done, 0);
    chk("f1_idle_ready", din_ready, 1);
    chk("f1_idle_busy", busy, 0);

    // Back-to-back 0110 then 1001 with din_valid held high
    din = 4'b0110; din_valid = 1'b1;
    step();
    a1 = last_acc;
    acc0 = acc_cnt;
    din = 4'b1001;
    repeat (4) step();
    chk("b2b_done1", frame_done, 1);
    chk("b2b_q1", q, 4'b0110);
    chk("b2b_noacc", acc_cnt, acc0);
    step();
    chk("b2b_ready", din_ready, 1);
    step();
    din_valid = 1'b0;
    chk("b2b_acc2", acc_cnt, acc0 + 1);
    chk("b2b_spacing", last_acc - a1, 6);
    repeat (4) step();
    chk("b2b_done2", frame_done, 1);
    chk("b2b_q2", q, 4'b1001);
    step();

    // Abort in the 2nd shift cycle
    fd0 = fd_cnt;
    din = 4'b1100; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    chk("ab_in_shift", shift_en, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_shen", shift_en, 0);
    chk("ab_ready", din_ready, 1);
    chk("ab_busy", busy, 0);
    repeat (4) step();
    chk("ab_nodone", fd_cnt, fd0);

    // din_valid pulsed while busy is ignored
    acc0 = acc_cnt;
    word = 4'b0101;
    din = word; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("ig_ser%0d", i), serial_out, word[W-1-i]);
      if (i == 1) begin
        din = 4'b1111; din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      step();
    end
    din_valid = 1'b0;
    chk("ig_done", frame_done, 1);
    chk("ig_q", q, 4'b0101);
    chk("ig_acc", acc_cnt, acc0 + 1);
    step();
    step();
    chk("ig_idle_nostart", busy, 0);

    // Reset in the 3rd shift cycle, then a clean frame
    fd0 = fd_cnt;
    din = 4'b1110; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step(); step();
    chk("rs_in_shift", shift_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_ready", din_ready, 1);
    chk("rs_busy", busy, 0);
    chk("rs_shen", shift_en, 0);
    chk("rs_ser", serial_out, 0);
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("rs_nodone", fd_cnt, fd0);
    word = 4'b0011;
    din = word; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("rs2_fstart", frame_start, 1);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("rs2_ser%0d", i), serial_out, word[W-1-i]);
      step();
    end
    chk("rs2_done", frame_done, 1);
    chk("rs2_q", q, 4'b0011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
